// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the width/total helpers used to size the raster counters.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int vga_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_H_TOTAL = vga_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = vga_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_delay_line.sv
// N-stage enabled shift register with synchronous clear; N = 0 is a single register stage.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int N     = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [0:N];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i <= N; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i <= N; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[N];

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster generator: pixel-enable counters, sync/DE decode, latency-matched
// sync delay line, line/frame pulses and a frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int COLOR_W  = 3,
  parameter int LAT      = 1,
  parameter int FRAME_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_en,
  input  logic [COLOR_W-1:0]  rgb,
  output logic [vga_clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP))-1:0] x_pos,
  output logic [vga_clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))-1:0] y_pos,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [COLOR_W-1:0]  color,
  output logic                line_start,
  output logic                frame_start,
  output logic [FRAME_W-1:0]  frame_cnt
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = vga_clog2(H_TOTAL);
  localparam int VW      = vga_clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  // Decode bounds carry one spare bit so a sync ending exactly at the total still fits.
  localparam logic [HW:0]   H_ACT    = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_HS_BEG = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_HS_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT    = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_VS_BEG = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_VS_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]      r_h_cnt;
  logic [VW-1:0]      r_v_cnt;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               r_line_start;
  logic               r_frame_start;

  logic               w_h_wrap;
  logic               w_v_wrap;
  logic [HW-1:0]      w_h_next;
  logic [VW-1:0]      w_v_next;
  logic               w_hs_raw;
  logic               w_vs_raw;
  logic               w_de_raw;
  logic [2:0]         w_dly_q;

  // Decode looks at the values the counters are about to take, so registering it keeps
  // the zero-latency syncs aligned with x_pos/y_pos.
  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_v_wrap = (r_v_cnt == V_LAST);
    w_h_next = w_h_wrap ? '0 : r_h_cnt + HW'(1);
    w_v_next = r_v_cnt;
    if (w_h_wrap) w_v_next = w_v_wrap ? '0 : r_v_cnt + VW'(1);
    w_hs_raw = ({1'b0, w_h_next} >= H_HS_BEG) && ({1'b0, w_h_next} < H_HS_END);
    w_vs_raw = ({1'b0, w_v_next} >= V_VS_BEG) && ({1'b0, w_v_next} < V_VS_END);
    w_de_raw = ({1'b0, w_h_next} < H_ACT) && ({1'b0, w_v_next} < V_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_cnt   <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (pix_en) begin
        r_h_cnt       <= w_h_next;
        r_v_cnt       <= w_v_next;
        r_line_start  <= w_h_wrap;
        r_frame_start <= w_h_wrap && w_v_wrap;
        if (w_h_wrap && w_v_wrap) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  vga_delay_line #(
    .WIDTH (3),
    .N     (LAT)
  ) u_dly (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (pix_en),
    .i_d   ({w_hs_raw, w_vs_raw, w_de_raw}),
    .o_q   (w_dly_q)
  );

  assign x_pos       = r_h_cnt;
  assign y_pos       = r_v_cnt;
  assign hsync       = (HS_POL != 0) ? w_dly_q[2] : ~w_dly_q[2];
  assign vsync       = (VS_POL != 0) ? w_dly_q[1] : ~w_dly_q[1];
  assign de          = w_dly_q[0];
  assign color       = w_dly_q[0] ? rgb : '0;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 14x8 raster: three instances (active-high LAT 0, active-low
// with 2-bit frame counter, LAT 3) compared against a tick-count raster model.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic clk;
  logic rst;
  logic pix_en;
  logic [2:0] rgb_a, rgb_b, rgb_c;

  logic [3:0]  x_a, x_b, x_c;
  logic [2:0]  y_a, y_b, y_c;
  logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, de_a, de_b, de_c;
  logic [2:0]  color_a, color_b, color_c;
  logic        ls_a, ls_b, ls_c, fs_a, fs_b, fs_c;
  logic [15:0] fc_a, fc_c;
  logic [1:0]  fc_b;

  int n_chk = 0;
  int n_err = 0;
  int t = 0;
  logic e_ls = 1'b0;
  logic e_fs = 1'b0;

  typedef struct {
    int   t;
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
    int   fc;
  } vec_t;
  vec_t vecs [13];

  logic [1:0] exp_q[$];

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(1), .COLOR_W(3), .LAT(0), .FRAME_W(16)) u_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .rgb(rgb_a), .x_pos(x_a), .y_pos(y_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .color(color_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_cnt(fc_a));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0), .COLOR_W(3), .LAT(0), .FRAME_W(2)) u_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .rgb(rgb_b), .x_pos(x_b), .y_pos(y_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .color(color_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_cnt(fc_b));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(1), .COLOR_W(3), .LAT(3), .FRAME_W(16)) u_c (
    .clk(clk), .rst(rst), .pix_en(pix_en), .rgb(rgb_c), .x_pos(x_c), .y_pos(y_c),
    .hsync(hs_c), .vsync(vs_c), .de(de_c), .color(color_c), .line_start(ls_c),
    .frame_start(fs_c), .frame_cnt(fc_c));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // raster model: position is a pure function of pix_en ticks since reset
  function automatic int px(input int tt);
    return tt % HT;
  endfunction
  function automatic int py(input int tt);
    return (tt / HT) % VT;
  endfunction
  function automatic logic hs_of(input int tt);
    return (px(tt) >= 10) && (px(tt) <= 12);
  endfunction
  function automatic logic vs_of(input int tt);
    return (py(tt) >= 5) && (py(tt) <= 6);
  endfunction
  function automatic logic de_of(input int tt);
    return (px(tt) < 8) && (py(tt) < 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, t);
    end
  endtask

  // driver: one clock edge with the given rst/pix_en, then advance the model
  task automatic tick(input logic r, input logic pe);
    int xd;
    rst    = r;
    pix_en = pe;
    @(posedge clk);
    #1;
    if (r) begin
      t = 0; e_ls = 1'b0; e_fs = 1'b0;
    end else if (pe) begin
      t++;
      e_ls = (t % HT == 0);
      e_fs = (t % FT == 0);
    end else begin
      e_ls = 1'b0; e_fs = 1'b0;
    end
    rgb_a = 3'($urandom_range(0, 7));
    rgb_b = 3'($urandom_range(0, 7));
    xd    = (t >= 3) ? px(t - 3) : 0;
    rgb_c = 3'(xd);
    #1;
  endtask

  // scoreboard compare of every output against the model
  task automatic check_model();
    logic h0, v0, d0, h3, v3, d3;
    int   xc;
    h0 = (t > 0) && hs_of(t);
    v0 = (t > 0) && vs_of(t);
    d0 = (t > 0) && de_of(t);
    h3 = (t > 3) && hs_of(t - 3);
    v3 = (t > 3) && vs_of(t - 3);
    d3 = (t > 3) && de_of(t - 3);
    xc = d3 ? (px(t - 3) % 8) : 0;
    chk("x_a", x_a, px(t));   chk("y_a", y_a, py(t));
    chk("x_b", x_b, px(t));   chk("y_b", y_b, py(t));
    chk("x_c", x_c, px(t));   chk("y_c", y_c, py(t));
    chk("hs_a", hs_a, h0);    chk("vs_a", vs_a, v0);    chk("de_a", de_a, d0);
    chk("hs_b", hs_b, !h0);   chk("vs_b", vs_b, !v0);   chk("de_b", de_b, d0);
    chk("hs_c", hs_c, h3);    chk("vs_c", vs_c, v3);    chk("de_c", de_c, d3);
    chk("color_a", color_a, d0 ? rgb_a : 3'd0);
    chk("color_b", color_b, d0 ? rgb_b : 3'd0);
    chk("color_c", color_c, xc);
    chk("ls_a", ls_a, e_ls);  chk("ls_b", ls_b, e_ls);  chk("ls_c", ls_c, e_ls);
    chk("fs_a", fs_a, e_fs);  chk("fs_b", fs_b, e_fs);  chk("fs_c", fs_c, e_fs);
    chk("fc_a", fc_a, (t / FT) % 65536);
    chk("fc_b", fc_b, (t / FT) % 4);
    chk("fc_c", fc_c, (t / FT) % 65536);
  endtask

  initial begin
    int   fs_cyc[$];
    int   spurious;
    logic prev_fs;
    logic [1:0] got;

    rst = 1'b1; pix_en = 1'b0; rgb_a = '0; rgb_b = '0; rgb_c = '0;

    // t, x, y, hs, vs, de, line_start, frame_start, frame_cnt
    vecs[0]  = '{1,   1,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1]  = '{7,   7,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{8,   8,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{10,  10, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{12,  12, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{13,  13, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{14,  0,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[7]  = '{56,  0,  4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[8]  = '{70,  0,  5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vecs[9]  = '{94,  10, 6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{98,  0,  7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vecs[11] = '{112, 0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1};
    vecs[12] = '{125, 13, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};

    // reset state, including inactive-low syncs on the inverted instance
    tick(1'b1, 1'b1);
    chk("rst_x", x_a, 0);   chk("rst_y", y_a, 0);   chk("rst_de", de_a, 0);
    chk("rst_hs_a", hs_a, 0); chk("rst_hs_b", hs_b, 1); chk("rst_vs_b", vs_b, 1);
    chk("rst_color", color_a, 0); chk("rst_fs", fs_a, 0); chk("rst_fc", fc_a, 0);
    check_model();

    // table vectors, continuous pix_en
    for (int i = 0; i < 13; i++) begin
      while (t < vecs[i].t) begin
        tick(1'b0, 1'b1);
        check_model();
      end
      chk("vec_x", x_a, vecs[i].x);    chk("vec_y", y_a, vecs[i].y);
      chk("vec_hs", hs_a, vecs[i].hs); chk("vec_vs", vs_a, vecs[i].vs);
      chk("vec_de", de_a, vecs[i].de); chk("vec_hs_inv", hs_b, !vecs[i].hs);
      chk("vec_vs_inv", vs_b, !vecs[i].vs);
      chk("vec_ls", ls_a, vecs[i].ls); chk("vec_fs", fs_a, vecs[i].fs);
      chk("vec_fc", fc_a, vecs[i].fc);
    end

    // pix_en every 4th clk: 448-clk frame period, 1-clk pulses
    tick(1'b1, 1'b0);
    prev_fs = 1'b0;
    for (int cyc = 0; cyc < 2 * 448 + 40; cyc++) begin
      tick(1'b0, (cyc % 4) == 3);
      check_model();
      chk("fs_width", fs_a && prev_fs, 0);
      if (fs_a) fs_cyc.push_back(cyc);
      prev_fs = fs_a;
    end
    chk("fs_count", fs_cyc.size(), 2);
    if (fs_cyc.size() >= 2) chk("fs_period", fs_cyc[1] - fs_cyc[0], 448);

    // reset mid-frame at (5,2) with pix_en low, then no spurious frame_start
    tick(1'b1, 1'b0);
    while (t < 2 * HT + 5) tick(1'b0, 1'b1);
    chk("pre_x", x_a, 5); chk("pre_y", y_a, 2);
    tick(1'b1, 1'b0);
    chk("mid_x", x_a, 0); chk("mid_y", y_a, 0); chk("mid_de", de_a, 0);
    chk("mid_hs", hs_a, 0); chk("mid_vs", vs_a, 0); chk("mid_hs_b", hs_b, 1);
    chk("mid_de_c", de_c, 0); chk("mid_fs", fs_a, 0);
    check_model();
    spurious = 0;
    for (int i = 0; i < FT - 1; i++) begin
      tick(1'b0, 1'b1);
      check_model();
      if (fs_a) spurious++;
    end
    chk("no_spurious_fs", spurious, 0);
    tick(1'b0, 1'b1);
    chk("fs_after_rst", fs_a, 1);

    // 2-bit frame counter over five frames, plus LAT 3 alignment on line 0 of frame 1
    tick(1'b1, 1'b0);
    exp_q = {2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5 * FT; i++) begin
      tick(1'b0, 1'b1);
      check_model();
      if (t == FT + 2) chk("lat3_de_before", de_c, 0);
      if (t == FT + 3) begin
        chk("lat3_de_rise", de_c, 1);
        chk("lat3_color", color_c, 3'(x_c - 4'd3));
      end
      if (fs_b) begin
        got = fc_b;
        if (exp_q.size() == 0) chk("fc_seq_extra", 1, 0);
        else chk("fc_seq", got, exp_q.pop_front());
      end
    end
    chk("fc_seq_left", exp_q.size(), 0);

    // randomized reset and pix_en duty cycle
    tick(1'b1, 1'b0);
    for (int seg = 0; seg < 15; seg++) begin
      int duty;
      duty = $urandom_range(1, 4);
      for (int i = 0; i < 200; i++) begin
        tick($urandom_range(0, 599) == 0, $urandom_range(1, duty) == 1);
        check_model();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator replacing the fixed 640x480 counter/colour pair in the display path. It produces hsync, vsync and data-enable from programmable porch/sync parameters with selectable polarity, and advances on a pixel-clock enable so it can share the system clock. A sync/DE delay line aligns the syncs with an external pixel pipeline of configurable latency, and a frame counter plus frame/line pulses give the game logic a frame tick.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync, in lines
- HS_POL / VS_POL, 1 / 1, sync active level; 1 = active high
- COLOR_W, 3, colour width
- LAT, 1, pixel-pipeline latency in pix_en ticks, legal range 0..4
- FRAME_W, 16, frame counter width

Ports (HW = clog2(H_TOTAL), VW = clog2(V_TOTAL)):
- clk  in  1  pixel/system clock; all state is on the rising edge
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; counters and delay line advance only when this is high
- rgb  in  COLOR_W  pixel colour from the external generator, LAT ticks behind x_pos/y_pos
- x_pos  out  HW  current horizontal count, 0..H_TOTAL-1
- y_pos  out  VW  current vertical count, 0..V_TOTAL-1
- hsync, vsync  out  1  delayed syncs at the configured polarity
- de  out  1  delayed active-video flag
- color  out  COLOR_W  rgb when de is high, otherwise 0
- line_start  out  1  one-clk pulse per line
- frame_start  out  1  one-clk pulse per frame
- frame_cnt  out  FRAME_W  frames completed since reset

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is formed the same way.
- On a pix_en tick, h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
- v_cnt wraps to 0 after V_TOTAL-1. When v_cnt wraps, frame_cnt increments, and frame_cnt wraps modulo 2^FRAME_W.
- x_pos and y_pos are the h_cnt and v_cnt registers driven directly.
- Decode, computed from the next counter values:
  - hs_raw is true when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is the same form on v. vsync spans whole lines and changes only at h wrap.
  - de_raw is true when h < H_ACTIVE and v < V_ACTIVE.
- Delay line: LAT stages, each loaded only on pix_en.
  - hsync = hs_delayed XNOR-free polarity mapped, i.e. hsync = HS_POL ? hs_d : ~hs_d. vsync is mapped the same way with VS_POL.
  - With LAT = 0 the decode is registered with no extra stages, so hsync, vsync and de describe the current x_pos/y_pos.
- color = de ? rgb : 0, combinational.
- line_start is high for one clk on the pix_en tick that loads h_cnt = 0.
- frame_start is high for one clk on the tick that loads (0,0).
- With pix_en low, all registers hold and both pulses stay low.

## Timing
- Reset values:
  - h_cnt, v_cnt, frame_cnt = 0.
  - Delay stages = 0, de = 0, color = 0, pulses = 0.
  - hsync = ~HS_POL and vsync = ~VS_POL, i.e. both inactive.
- First tick after reset:
  - x_pos goes to 1.
  - frame_start does not fire for the reset state. It fires first when the counters wrap to (0,0).
- Sync/de latency: LAT pix_en ticks relative to x_pos/y_pos. The delay is counted in ticks, not clocks, so it is independent of the pix_en duty cycle.
- Reset mid-frame: takes effect on the next clk edge regardless of pix_en. It clears the counters and the delay line, with no partial pulse.
- pix_en held high continuously gives one pixel per clk.

## Structure
- Package vga_pkg holds:
  - the default 640x480 timing constants,
  - the H_TOTAL/V_TOTAL derivations,
  - the constant clog2 width function.
- Sub-module vga_delay_line: generic N-stage shift register with enable and synchronous clear, WIDTH bits wide, N = 0 meaning a pass-through register. It is instantiated once, carrying {hs, vs, de}.
- Everything else (counters, decode, pulses, frame counter) lives in vga_timing_gen.

## Test plan
Scenarios 1-4 use small timing: H 8/2/3/1 (H_TOTAL = 14), V 4/1/2/1 (V_TOTAL = 8), LAT = 0, pix_en = 1.
1. Run one frame -> line_start every 14 clks.
   - hsync high at x = 10..12.
   - vsync high at y = 5..6.
   - de high for exactly 32 pixels per frame.
   - frame_start 112 clks apart.
2. HS_POL = 0, VS_POL = 0 -> sync waveforms are the exact inverses of scenario 1. After rst, hsync = vsync = 1.
3. pix_en = 1 every 4th clk -> x_pos steps every 4 clks, pulses stay 1 clk wide, frame period is 448 clks.
4. LAT = 3 with rgb driven = 3-tick-delayed x[2:0]:
   - de rises 3 ticks after x_pos = 0 on line 0.
   - color equals x - 3 within active video and is 0 in blanking.
5. FRAME_W = 2, run 5 frames -> frame_cnt sequence is 1, 2, 3, 0, 1.
6. Assert rst at x = 5, y = 2 -> next clk x_pos = y_pos = 0, de = 0, syncs inactive, delay line cleared. Normal timing resumes without a spurious frame_start.
